// File: rtl/prm_obstacle_scan.sv
// Obstacle-check initiator: feeds occupied-voxel codes to the external edge-check
// bank, ORs the returned edge masks together and streams the result out in words.
module prm_obstacle_scan #(
  parameter int CODE_W    = 15,
  parameter int NUM_EDGES = 1024,
  parameter int OUT_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_last,
  output logic [CODE_W-1:0]    chk_code,
  output logic                 chk_valid,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     code_count
);

  localparam int NUM_WORDS = NUM_EDGES / OUT_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DUMP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NUM_EDGES-1:0] acc_q, acc_d;
  logic [CODE_W-1:0]    chk_code_q, chk_code_d;
  logic                 chk_valid_q, chk_valid_d;
  logic [CNT_W-1:0]     code_count_q, code_count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;

  logic in_hs;
  logic out_hs;

  assign in_hs  = (state_q == ST_SCAN) && in_valid;
  assign out_hs = (state_q == ST_DUMP) && out_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    chk_code_d   = chk_code_q;
    chk_valid_d  = 1'b0;
    code_count_d = code_count_q;
    idx_d        = idx_q;
    done_d       = 1'b0;

    // Bank response is only meaningful for the code registered last cycle.
    if (chk_valid_q) begin
      acc_d = acc_q | chk_mask;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d        = '0;
          code_count_d = '0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (in_hs) begin
          chk_code_d  = in_code;
          chk_valid_d = 1'b1;
          if (code_count_q != '1) begin
            code_count_d = code_count_q + 1'b1;
          end
          if (in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        idx_d   = '0;
        state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (out_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      chk_code_q   <= '0;
      chk_valid_q  <= 1'b0;
      code_count_q <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      chk_code_q   <= chk_code_d;
      chk_valid_q  <= chk_valid_d;
      code_count_q <= code_count_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_SCAN);
  assign chk_code   = chk_code_q;
  assign chk_valid  = chk_valid_q;
  assign out_valid  = (state_q == ST_DUMP);
  // Word mux is gated so nothing of the retained mask leaks outside DUMP.
  assign out_data   = out_valid ? acc_q[int'(idx_q) * OUT_W +: OUT_W] : '0;
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign code_count = code_count_q;

endmodule

// File: tb/tb_prm_obstacle_scan.sv
// Randomized bench for prm_obstacle_scan: a behavioural edge-check bank plus an
// OR-of-masks reference predict every output word.
module tb_prm_obstacle_scan;

  localparam int CODE_W    = 15;
  localparam int NUM_EDGES = 1024;
  localparam int OUT_W     = 32;
  localparam int CNT_W     = 16;
  localparam int NW        = NUM_EDGES / OUT_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [CODE_W-1:0]    in_code;
  logic                 in_last;
  logic [CODE_W-1:0]    chk_code;
  logic                 chk_valid;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     code_count;

  int errors = 0;
  int checks = 0;
  int bank_mode = 0;
  logic [NUM_EDGES-1:0] exp_mask;

  always #5 clk = ~clk;

  prm_obstacle_scan #(
    .CODE_W(CODE_W), .NUM_EDGES(NUM_EDGES), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_last(in_last),
    .chk_code(chk_code), .chk_valid(chk_valid), .chk_mask(chk_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .code_count(code_count)
  );

  // Edge-check bank: which roadmap edges a given occupied voxel blocks.
  function automatic logic [NUM_EDGES-1:0] bank(input logic [CODE_W-1:0] c, input int mode);
    logic [NUM_EDGES-1:0] m;
    int v;
    m = '0;
    v = int'(c);
    case (mode)
      1: begin
        if (c == 15'h4000) begin
          m[3]  = 1'b1;
          m[40] = 1'b1;
        end else begin
          m[v % NUM_EDGES] = 1'b1;
        end
      end
      2: begin
        m[v % NUM_EDGES]            = 1'b1;
        m[(v * 37 + 11) % NUM_EDGES] = 1'b1;
      end
      default: m[v % NUM_EDGES] = 1'b1;
    endcase
    return m;
  endfunction

  // Garbage while chk_valid is low: the DUT must ignore it.
  always_comb chk_mask = chk_valid ? bank(chk_code, bank_mode) : '1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, code_count, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_chk_valid"}, chk_valid, 0);
    check({tag, "_chk_code"}, chk_code, 0);
  endtask

  // code_sel: 0 random, 1 fixed 15'h4000. Leaves the DUT entering DUMP.
  task automatic scan(input int n, input int gap_pct, input int code_sel, input bit poke_start);
    int acc_n;
    int cyc;
    int exp_cnt;
    acc_n = 0;
    cyc = 0;
    exp_mask = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_scan", busy, 1);
    while (acc_n < n && cyc < n * 4 + 100) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_code  = (code_sel == 1) ? 15'h4000 : CODE_W'($urandom);
      in_last  = (acc_n == n - 1);
      start    = poke_start && (acc_n == n / 2);
      @(negedge clk);
      check("in_ready_scan", in_ready, 1);
      if (in_valid && in_ready) begin
        exp_mask |= bank(in_code, bank_mode);
        acc_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    if (acc_n < n) check("scan_timeout", acc_n, n);
    exp_cnt = (n > 65535) ? 65535 : n;
    check("in_ready_drain", in_ready, 0);
    check("out_valid_drain", out_valid, 0);
    check("busy_drain", busy, 1);
    check("code_count", code_count, exp_cnt);
    @(posedge clk); #1;
  endtask

  // rmode: 0 always ready, 1 pattern 1-0-0-1, 2 random. abort_at<0: no reset.
  task automatic dump(input int rmode, input int abort_at, input bit poke_start);
    int w;
    int cyc;
    logic [OUT_W-1:0] pd;
    logic pl;
    logic pstall;
    w = 0;
    cyc = 0;
    pstall = 1'b0;
    pd = '0;
    pl = 1'b0;
    while (w < NW && cyc < 400) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      start = poke_start && (cyc == 3);
      @(negedge clk);
      if (w == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        start = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      check("out_valid_dump", out_valid, 1);
      if (pstall) begin
        check("stall_data", out_data, pd);
        check("stall_last", out_last, pl);
      end
      if (out_ready) begin
        check($sformatf("word%0d", w), out_data, exp_mask[w * OUT_W +: OUT_W]);
        check($sformatf("last%0d", w), out_last, (w == NW - 1));
        w++;
      end
      pstall = !out_ready;
      pd = out_data;
      pl = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (w < NW) check("dump_timeout", w, NW);
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("out_valid_after", out_valid, 0);
    @(posedge clk); #1;
    check("done_clear", done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_code = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    bank_mode = 1;
    scan(1, 0, 1, 1'b0);
    dump(0, -1, 1'b0);
    check("count_single", code_count, 1);

    bank_mode = 0;
    scan(100, 0, 0, 1'b0);
    dump(1, -1, 1'b0);

    bank_mode = 2;
    scan(200, 30, 0, 1'b1);
    dump(2, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("count_idle", code_count, 200);

    scan(50, 20, 0, 1'b0);
    dump(0, 10, 1'b0);
    check("abort_idle_busy", busy, 0);
    scan(30, 0, 0, 1'b0);
    dump(2, -1, 1'b0);

    bank_mode = 0;
    scan(65540, 0, 0, 1'b0);
    dump(0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
